// File: rtl/pulse_pkg.sv
// Shared constants for the pulse train sequencer: FSM state encoding and default widths.
package pulse_pkg;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_NUM_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter with a zero flag; times both the high and the gap phase.
module pulse_timer
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/pulse_train_sequencer.sv
// Burst pulse sequencer: N pulses of programmable width separated by programmable gaps.
// Build option PULSE_CONT_EN: cfg_count=0 runs continuously until abort.
module pulse_train_sequencer
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [NUM_W-1:0] cfg_count,
  output logic             busy,
  output logic             done,
  output logic             PULSE_O,
  output logic [NUM_W-1:0] pulses_sent
);

`ifdef PULSE_CONT_EN
  localparam logic CONT_EN = 1'b1;
`else
  localparam logic CONT_EN = 1'b0;
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_gap;
  logic [NUM_W-1:0] r_count;
  logic             r_cont;
  logic [NUM_W-1:0] r_sent;
  logic             r_busy;
  logic             r_done;
  logic             r_pulse;

  logic             w_load;
  logic             w_en;
  logic [CNT_W-1:0] w_load_val;
  logic             w_accept;
  logic             w_inc;
  logic             w_cont_req;
  logic             w_last;
  logic             w_zero;

  // Phase lengths of 0 behave as 1; the timer expires when it reaches zero.
  function automatic logic [CNT_W-1:0] clamp_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (w_load_val),
    .o_zero_c   (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = IDLE;
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = '0;
    w_accept   = 1'b0;
    w_inc      = 1'b0;
    w_cont_req = CONT_EN && (cfg_count == '0);
    w_last     = !r_cont && (NUM_W'(r_sent + NUM_W'(1)) == r_count);
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_accept = 1'b1;
          if ((cfg_count == '0) && !w_cont_req) begin
            w_next = DONE;
          end else begin
            w_next     = HIGH;
            w_load     = 1'b1;
            w_load_val = clamp_m1(cfg_width);
          end
        end
      end
      HIGH: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_zero) begin
          w_inc = 1'b1;
          if (w_last) begin
            w_next = DONE;
          end else begin
            w_next     = LOW;
            w_load     = 1'b1;
            w_load_val = clamp_m1(r_gap);
          end
        end else begin
          w_next = HIGH;
          w_en   = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_zero) begin
          w_next     = HIGH;
          w_load     = 1'b1;
          w_load_val = clamp_m1(r_width);
        end else begin
          w_next = LOW;
          w_en   = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_width <= '0;
      r_gap   <= '0;
      r_count <= '0;
      r_cont  <= 1'b0;
      r_sent  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_busy  <= (w_next == HIGH) || (w_next == LOW);
      r_done  <= (w_next == DONE);
      r_pulse <= (w_next == HIGH);
      if (w_accept) begin
        r_width <= cfg_width;
        r_gap   <= cfg_gap;
        r_count <= cfg_count;
        r_cont  <= w_cont_req;
        r_sent  <= '0;
      end else if (w_inc) begin
        r_sent  <= NUM_W'(r_sent + NUM_W'(1));
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign PULSE_O     = r_pulse;
  assign pulses_sent = r_sent;

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Randomized self-checking bench: expected per-cycle waveforms built from burst rules.
module tb_pulse_train_sequencer;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NUM_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [NUM_W-1:0] cfg_count;
  logic             busy;
  logic             done;
  logic             PULSE_O;
  logic [NUM_W-1:0] pulses_sent;

  int errors = 0;
  int checks = 0;

  pulse_train_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_width   (cfg_width),
    .cfg_gap     (cfg_gap),
    .cfg_count   (cfg_count),
    .busy        (busy),
    .done        (done),
    .PULSE_O     (PULSE_O),
    .pulses_sent (pulses_sent)
  );

  always #5 clk = ~clk;

  // Observed word: {PULSE_O, busy, done, pulses_sent}
  logic [NUM_W+2:0] obs;
  assign obs = {PULSE_O, busy, done, pulses_sent};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pulse,busy,done,sent)", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_W+2:0] mk(input bit p, input bit b, input bit d, input int s);
    logic [NUM_W-1:0] sv;
    sv = NUM_W'(s);
    return {p, b, d, sv};
  endfunction

  task automatic scramble_cfg();
    cfg_width = CNT_W'($urandom_range(0, 9));
    cfg_gap   = CNT_W'($urandom_range(0, 9));
    cfg_count = NUM_W'($urandom_range(0, 9));
  endtask

  // Runs one burst; abort_k/rst_k choose a displayed cycle after which abort/rst is raised (-1: none).
  task automatic run_burst(input string name, input int w, input int g, input int n,
                           input int abort_k, input int rst_k);
    logic [NUM_W+2:0] q[$];
    int wc, gc;
    logic [NUM_W-1:0] held;
    wc = (w == 0) ? 1 : w;
    gc = (g == 0) ? 1 : g;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < wc; c++) q.push_back(mk(1, 1, 0, i));
      if (i < n - 1)
        for (int c = 0; c < gc; c++) q.push_back(mk(0, 1, 0, i + 1));
    end
    q.push_back(mk(0, 0, 1, n));
    q.push_back(mk(0, 0, 0, n));

    @(negedge clk);
    cfg_width = CNT_W'(w);
    cfg_gap   = CNT_W'(g);
    cfg_count = NUM_W'(n);
    start = 1'b1;
    abort = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      start = 1'b0;
      scramble_cfg();
      check($sformatf("%s k=%0d", name, k), 32'(obs), 32'(q[k]));
      if (k == abort_k && k < q.size() - 2) begin
        held  = q[k][NUM_W-1:0];
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check($sformatf("%s abort", name), 32'(obs), 32'(mk(0, 0, 0, int'(held))));
        @(negedge clk);
        check($sformatf("%s abort idle", name), 32'(obs), 32'(mk(0, 0, 0, int'(held))));
        return;
      end
      if (k == rst_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check($sformatf("%s reset", name), 32'(obs), 32'(mk(0, 0, 0, 0)));
        return;
      end
      // Stray starts while busy and in the DONE cycle must be ignored.
      if (k == q.size() - 2)      start = 1'b1;
      else if (k < q.size() - 2)  start = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int w, g, n, ak;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_width = '0;
    cfg_gap = '0;
    cfg_count = '0;
    repeat (2) @(negedge clk);
    check("reset", 32'(obs), 32'(mk(0, 0, 0, 0)));
    rst = 1'b0;

    run_burst("basic", 3, 2, 4, -1, -1);
    run_burst("clamp", 0, 0, 3, -1, -1);
    run_burst("abort", 5, 5, 10, 12, -1);

    // start together with abort in IDLE does nothing
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    cfg_width = 16'd2; cfg_gap = 16'd2; cfg_count = 8'd2;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start+abort", 32'(obs), 32'(mk(0, 0, 0, 1)));

    run_burst("rst_low", 3, 4, 3, -1, 4);
    run_burst("fresh", 2, 3, 3, -1, -1);

`ifdef PULSE_CONT_EN
    @(negedge clk);
    cfg_width = 16'd1; cfg_gap = 16'd1; cfg_count = 8'd0;
    start = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("cont k=%0d", k), 32'(obs), 32'(mk((k % 2) == 0, 1, 0, ((k + 1) / 2) % 256)));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("cont abort", 32'(obs), 32'(mk(0, 0, 0, 44)));
`else
    run_burst("count0", 4, 4, 0, -1, -1);
`endif

    for (int r = 0; r < 25; r++) begin
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 4);
`ifdef PULSE_CONT_EN
      n = $urandom_range(1, 5);
`else
      n = $urandom_range(0, 5);
`endif
      ak = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : -1;
      run_burst($sformatf("rnd%0d", r), w, g, n, ak, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end expected end of run");
    $fatal(1, "timeout");
  end

endmodule
